turbo_encoder_param: RTL and testbench
======================================

TURBO_ENCODER_PARAM -- requirements
Module: turbo_encoder_param

Interface
REQ-001 Parameter K, default 40, sets block length in bits; legal range 40..6144.
REQ-002 Parameter F1, default 3, is the QPP linear coefficient.
REQ-003 Parameter F2, default 10, is the QPP quadratic coefficient; the integrator SHALL supply a (K,F1,F2) that forms a valid permutation.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 ack  input  1  start-of-block strobe, high with bit 0.
REQ-007 mode  input  1  output format: 1 = parallel, 0 = serial.
REQ-008 in_MSD_CRC  input  1  serial input bit (MSD+CRC stream).
REQ-009 out_TE_data  output  1  serial coded bit; in parallel mode it carries the systematic bit.
REQ-010 out_TE_par  output  3  parallel coded triplet {z', z, x}.
REQ-011 out_valid  output  1  outputs carry valid coded data this cycle.
REQ-012 busy  output  1  a block is being loaded or encoded.
REQ-013 done  output  1  one-cycle pulse after the last coded bit.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, ENC and TAIL; reset SHALL enter IDLE.
REQ-015 In IDLE, ack=1 SHALL write in_MSD_CRC to buffer[0], latch mode, set bit count to 1 and enter LOAD.
REQ-016 LOAD SHALL write one bit per cycle to buffer[count]; the edge that writes bit K-1 SHALL enter ENC.
REQ-017 ack while busy=1 SHALL be ignored; input is ignored outside IDLE/LOAD.
REQ-018 mode changes after the latch edge SHALL have no effect on the current block.
REQ-019 Interleaver address SHALL be computed recursively, with no multiplier:
  - pi(0)=0, g(0)=(F1+F2) mod K
  - pi(i+1)=(pi(i)+g(i)) mod K
  - g(i+1)=(g(i)+2*F2) mod K
  - every modulo SHALL be a single conditional subtract.
REQ-020 Both RSC encoders SHALL use g0=1+D^2+D^3 (feedback) and g1=1+D+D^3 (parity), with 3-bit state s:
  - a = u^s2^s3
  - z = a^s1^s3
  - next s = {a,s1,s2}
  - both states SHALL be zero at the start of ENC.
REQ-021 Encoder 1 input SHALL be buffer[i]; encoder 2 input SHALL be buffer[pi(i)]; x = buffer[i].
REQ-022 Parallel mode: one triplet per cycle for i=0..K-1, then 6 TAIL cycles, for K+6 valid cycles in total.
REQ-023 Serial mode: x, z, z' over 3 cycles per i, then 12 TAIL bits, for 3K+12 valid cycles in total.
REQ-024 TAIL termination:
  - encoder 1 SHALL run 3 steps, then encoder 2 SHALL run 3 steps.
  - each step uses u = s2^s3 (so a=0) and emits x_t=u and z_t.
  - parallel: out_TE_par={1'b0,z_t,x_t}; serial: x_t then z_t.
  - both states SHALL end at zero.
REQ-025 Outputs SHALL be registered; the first out_valid SHALL appear on the edge after the ENC-entry edge.
REQ-026 out_valid SHALL be continuous, with no gaps, from first to last coded bit.
REQ-027 done SHALL pulse on the edge after the last valid bit, together with the return to IDLE; busy SHALL fall on that same edge.
REQ-028 An ack in the cycle done is high SHALL be accepted as a new block.
REQ-029 Counter widths SHALL be $clog2(3K+12)+1 bits; pi and g SHALL be $clog2(K) bits.

Reset
REQ-030 rst=1 SHALL asynchronously force:
  - state to IDLE
  - all counters, encoder states, pi and g to 0
  - out_TE_data, out_TE_par, out_valid, busy and done to 0
  - buffer contents are don't-care.
REQ-031 Reset mid-LOAD, mid-ENC or mid-TAIL SHALL abort the block; no further out_valid SHALL occur until a new full block is loaded.

Structure
REQ-032 Package turbo_pkg SHALL hold the FSM state type, the generator polynomial constants, TAIL_STEPS=3 and the serial phase-count constant.
REQ-033 Sub-module rsc_encoder SHALL hold the constituent encoder (state, step and tail-mode inputs; x_t and z outputs) and SHALL be instantiated twice; all other logic stays in turbo_encoder_param.

Verification
REQ-034 K=40, all-zero block, parallel -> 46 valid cycles, all outputs 0, done one cycle after the last.
REQ-035 K=40, bit0=1 only, parallel -> cycle 0 out_TE_par=3'b111; tail ends with zero encoder states.
REQ-036 K=40, bit13=1 only, parallel -> out_TE_par[2]=1 at cycle 1 (pi(1)=13), and x=1 at cycle 13.
REQ-037 K=40, random block, serial -> exactly 132 contiguous valid bits, matching the golden model bit-exactly.
REQ-038 ack pulsed during ENC -> ignored, output unchanged; rst asserted mid-ENC -> all outputs 0 immediately, and the next block encodes correctly.
REQ-039 Back-to-back blocks with ack on the done cycle, alternating mode -> both blocks correct, with no lost bits.

Source files
------------

// File: rtl/turbo_pkg.sv
// Shared definitions for the QPP turbo encoder: FSM states, RSC generator
// polynomials, tail/serial constants and the constituent-code helpers.
package turbo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ENC  = 2'd2,
    ST_TAIL = 2'd3
  } state_t;

  // Bit i is the coefficient of D^i.
  localparam logic [3:0] G0_POLY = 4'b1101;  // 1 + D^2 + D^3 (feedback)
  localparam logic [3:0] G1_POLY = 4'b1011;  // 1 + D + D^3   (parity)

  localparam int TAIL_STEPS    = 3;
  localparam int SERIAL_PHASES = 3;

  // Feedback value a for input u; state s is {s3, s2, s1}.
  function automatic logic rsc_fb(input logic u, input logic [2:0] s);
    return (G0_POLY[0] & u) ^ (^(s & G0_POLY[3:1]));
  endfunction

  // Parity output z for feedback value a and state s = {s3, s2, s1}.
  function automatic logic rsc_par(input logic a, input logic [2:0] s);
    return (G1_POLY[0] & a) ^ (^(s & G1_POLY[3:1]));
  endfunction

endpackage

// File: rtl/rsc_encoder.sv
// Constituent recursive systematic convolutional encoder. Outputs are
// combinational from the current state; the state advances only on step.
// In tail mode the input is replaced by the feedback so the register drains.
module rsc_encoder
  import turbo_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic step,
  input  logic tail,
  input  logic u,
  output logic x_t,
  output logic z
);

  logic [2:0] state_r;   // {s3, s2, s1}
  logic       u_eff_s;
  logic       a_s;

  // Effective input, feedback value and parity for the current state
  always_comb begin
    u_eff_s = tail ? rsc_fb(1'b0, state_r) : u;
    a_s     = rsc_fb(u_eff_s, state_r);
    x_t     = u_eff_s;
    z       = rsc_par(a_s, state_r);
  end

  // Shift register: new s1 = a, s2 = old s1, s3 = old s2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= 3'b000;
    end else if (clr) begin
      state_r <= 3'b000;
    end else if (step) begin
      state_r <= {state_r[1], state_r[0], a_s};
    end else begin
      state_r <= state_r;
    end
  end

endmodule

// File: rtl/turbo_encoder_param.sv
// Rate-1/3 turbo encoder with QPP interleaver. A K-bit block is loaded
// serially, then encoded by two RSC encoders and emitted as parallel
// triplets {z', z, x} or as a serial x, z, z' bit stream, followed by
// trellis termination of encoder 1 and then encoder 2.
module turbo_encoder_param #(
  parameter int K  = 40,
  parameter int F1 = 3,
  parameter int F2 = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ack,
  input  logic       mode,
  input  logic       in_MSD_CRC,
  output logic       out_TE_data,
  output logic [2:0] out_TE_par,
  output logic       out_valid,
  output logic       busy,
  output logic       done
);
  import turbo_pkg::*;

  localparam int CW = $clog2(3*K + 12) + 1;
  localparam int PW = $clog2(K);

  localparam logic [PW-1:0] G_INIT   = PW'((F1 + F2) % K);
  localparam logic [PW-1:0] TWO_F2   = PW'((2 * F2) % K);
  localparam logic [PW:0]   K_EXT    = (PW+1)'(K);
  localparam logic [PW-1:0] K_LO     = PW'(K);
  localparam logic [CW-1:0] LAST_IDX = CW'(K - 1);
  localparam logic [CW-1:0] TAIL_SEL = CW'(TAIL_STEPS);
  localparam logic [CW-1:0] TAIL_END = CW'(2 * TAIL_STEPS);
  localparam logic [1:0]    PH_LAST  = 2'(SERIAL_PHASES - 1);

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [1:0]    phase_r, phase_s;
  logic [PW-1:0] pi_r, pi_s;
  logic [PW-1:0] g_r, g_s;
  logic          mode_r, mode_s;
  logic [K-1:0]  buf_r;

  logic          wr_en_s;
  logic [PW-1:0] wr_addr_s;
  logic          clr_s, tail_s, step1_s, step2_s;
  logic          adv_s, sel2_s, xt_s, zt_s;
  logic          valid_s, data_s, done_s, busy_s;
  logic [2:0]    par_s;

  logic [PW:0]   pi_sum_s, g_sum_s;
  logic [PW-1:0] pi_next_s, g_next_s;
  logic          u1_s, u2_s, x1_s, z1_s, x2_s, z2_s;

  // Recursive QPP address update: each modulo is one conditional subtract
  always_comb begin
    pi_sum_s  = {1'b0, pi_r} + {1'b0, g_r};
    g_sum_s   = {1'b0, g_r} + {1'b0, TWO_F2};
    pi_next_s = (pi_sum_s >= K_EXT) ? (pi_sum_s[PW-1:0] - K_LO) : pi_sum_s[PW-1:0];
    g_next_s  = (g_sum_s >= K_EXT) ? (g_sum_s[PW-1:0] - K_LO) : g_sum_s[PW-1:0];
    u1_s      = buf_r[cnt_r[PW-1:0]];
    u2_s      = buf_r[pi_r];
  end

  rsc_encoder u_enc1 (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_s),
    .step (step1_s),
    .tail (tail_s),
    .u    (u1_s),
    .x_t  (x1_s),
    .z    (z1_s)
  );

  rsc_encoder u_enc2 (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_s),
    .step (step2_s),
    .tail (tail_s),
    .u    (u2_s),
    .x_t  (x2_s),
    .z    (z2_s)
  );

  // Next-state, counter and output-data logic of the block FSM
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    phase_s   = phase_r;
    pi_s      = pi_r;
    g_s       = g_r;
    mode_s    = mode_r;
    wr_en_s   = 1'b0;
    wr_addr_s = cnt_r[PW-1:0];
    clr_s     = 1'b0;
    tail_s    = 1'b0;
    step1_s   = 1'b0;
    step2_s   = 1'b0;
    adv_s     = 1'b0;
    sel2_s    = 1'b0;
    xt_s      = 1'b0;
    zt_s      = 1'b0;
    valid_s   = 1'b0;
    data_s    = 1'b0;
    par_s     = 3'b000;
    done_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        clr_s = 1'b1;
        if (ack) begin
          wr_en_s   = 1'b1;
          wr_addr_s = {PW{1'b0}};
          mode_s    = mode;
          cnt_s     = {{(CW-1){1'b0}}, 1'b1};
          state_s   = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        clr_s   = 1'b1;
        wr_en_s = 1'b1;
        if (cnt_r == LAST_IDX) begin
          state_s = ST_ENC;
          cnt_s   = {CW{1'b0}};
          phase_s = 2'd0;
          pi_s    = {PW{1'b0}};
          g_s     = G_INIT;
        end else begin
          cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ST_ENC: begin
        valid_s = 1'b1;
        if (mode_r) begin
          data_s = x1_s;
          par_s  = {z2_s, z1_s, x1_s};
          adv_s  = 1'b1;
        end else begin
          case (phase_r)
            2'd0:    data_s = x1_s;
            2'd1:    data_s = z1_s;
            default: data_s = z2_s;
          endcase
          adv_s   = (phase_r == PH_LAST);
          phase_s = adv_s ? 2'd0 : (phase_r + 2'd1);
        end
        if (adv_s) begin
          step1_s = 1'b1;
          step2_s = 1'b1;
          pi_s    = pi_next_s;
          g_s     = g_next_s;
          if (cnt_r == LAST_IDX) begin
            state_s = ST_TAIL;
            cnt_s   = {CW{1'b0}};
          end else begin
            cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_TAIL: begin
        tail_s = 1'b1;
        if (cnt_r < TAIL_END) begin
          valid_s = 1'b1;
          sel2_s  = (cnt_r >= TAIL_SEL);
          xt_s    = sel2_s ? x2_s : x1_s;
          zt_s    = sel2_s ? z2_s : z1_s;
          if (mode_r) begin
            data_s = xt_s;
            par_s  = {1'b0, zt_s, xt_s};
            adv_s  = 1'b1;
          end else begin
            data_s  = (phase_r == 2'd0) ? xt_s : zt_s;
            adv_s   = (phase_r == 2'd1);
            phase_s = adv_s ? 2'd0 : 2'd1;
          end
          if (adv_s) begin
            step1_s = ~sel2_s;
            step2_s = sel2_s;
            cnt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end else begin
            cnt_s = cnt_r;
          end
        end else begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
          cnt_s   = {CW{1'b0}};
          phase_s = 2'd0;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CW{1'b0}};
        phase_s = 2'd0;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // Block buffer; contents after reset are irrelevant so it carries no reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      buf_r[wr_addr_s] <= in_MSD_CRC;
    end else begin
      buf_r <= buf_r;
    end
  end

  // FSM, counters, interleaver registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CW{1'b0}};
      phase_r     <= 2'd0;
      pi_r        <= {PW{1'b0}};
      g_r         <= {PW{1'b0}};
      mode_r      <= 1'b0;
      out_TE_data <= 1'b0;
      out_TE_par  <= 3'b000;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      phase_r     <= phase_s;
      pi_r        <= pi_s;
      g_r         <= g_s;
      mode_r      <= mode_s;
      out_TE_data <= data_s;
      out_TE_par  <= par_s;
      out_valid   <= valid_s;
      busy        <= busy_s;
      done        <= done_s;
    end
  end

endmodule

// File: tb/tb_turbo_encoder_param.sv
// Scoreboard bench for turbo_encoder_param (K=40, F1=3, F2=10).
module tb_turbo_encoder_param;

  localparam int K  = 40;
  localparam int F1 = 3;
  localparam int F2 = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ack = 1'b0;
  logic       mode = 1'b0;
  logic       in_bit = 1'b0;
  logic       out_TE_data;
  logic [2:0] out_TE_par;
  logic       out_valid;
  logic       busy;
  logic       done;

  typedef struct packed {
    logic       data;
    logic [2:0] par;
    logic       chk_par;
    logic       last;
  } item_t;

  item_t exp_q[$];
  int    len_q[$];
  int    checks = 0;
  int    errors = 0;

  turbo_encoder_param #(.K(K), .F1(F1), .F2(F2)) dut (
    .clk         (clk),
    .rst         (rst),
    .ack         (ack),
    .mode        (mode),
    .in_MSD_CRC  (in_bit),
    .out_TE_data (out_TE_data),
    .out_TE_par  (out_TE_par),
    .out_valid   (out_valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Golden RSC step; s = {s1, s2, s3}; returns {z, next s}
  function automatic logic [3:0] model_step(input logic u, input logic [2:0] s);
    logic a;
    a = u ^ s[1] ^ s[0];
    return {a ^ s[2] ^ s[0], a, s[2], s[1]};
  endfunction

  // Direct QPP formula, independent of the recursive hardware form
  function automatic int qpp(input int i);
    return (F1 * i + F2 * i * i) % K;
  endfunction

  function automatic item_t mk(input logic d, input logic [2:0] p, input logic c, input logic l);
    item_t it;
    it.data = d; it.par = p; it.chk_par = c; it.last = l;
    return it;
  endfunction

  task automatic push_block(input logic [K-1:0] b, input logic m);
    logic [2:0] s1, s2;
    logic [3:0] r1, r2, rt;
    logic       x, u, z, l;
    s1 = 3'b000;
    s2 = 3'b000;
    for (int i = 0; i < K; i++) begin
      x  = b[i];
      r1 = model_step(x, s1);
      r2 = model_step(b[qpp(i)], s2);
      s1 = r1[2:0];
      s2 = r2[2:0];
      if (m) begin
        exp_q.push_back(mk(x, {r2[3], r1[3], x}, 1'b1, 1'b0));
      end else begin
        exp_q.push_back(mk(x, 3'b000, 1'b0, 1'b0));
        exp_q.push_back(mk(r1[3], 3'b000, 1'b0, 1'b0));
        exp_q.push_back(mk(r2[3], 3'b000, 1'b0, 1'b0));
      end
    end
    for (int t = 0; t < 6; t++) begin
      if (t < 3) begin
        u  = s1[1] ^ s1[0];
        rt = model_step(u, s1);
        s1 = rt[2:0];
      end else begin
        u  = s2[1] ^ s2[0];
        rt = model_step(u, s2);
        s2 = rt[2:0];
      end
      z = rt[3];
      l = (t == 5);
      if (m) begin
        exp_q.push_back(mk(u, {1'b0, z, u}, 1'b1, l));
      end else begin
        exp_q.push_back(mk(u, 3'b000, 1'b0, 1'b0));
        exp_q.push_back(mk(z, 3'b000, 1'b0, l));
      end
    end
    len_q.push_back(m ? 46 : 132);
  endtask

  // Load a block; mode is flipped after the latch cycle and must not matter
  task automatic send_block(input logic [K-1:0] b, input logic m, input logic start_now);
    push_block(b, m);
    for (int i = 0; i < K; i++) begin
      if (!(start_now && i == 0)) @(negedge clk);
      ack    = (i == 0);
      in_bit = b[i];
      mode   = (i == 0) ? m : ~m;
    end
    @(negedge clk);
    ack    = 1'b0;
    in_bit = 1'b0;
    chk("enc_entry_no_valid", {31'd0, out_valid}, 32'd0);
    chk("busy_at_enc_entry", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("first_valid_latency", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_within_budget", {31'd0, seen}, 32'd1);
  endtask

  // Monitor: pops the scoreboard on each valid output and checks framing
  initial begin : monitor
    item_t it;
    logic  in_block;
    logic  expect_done;
    int    vcount;
    int    len;
    in_block    = 1'b0;
    expect_done = 1'b0;
    vcount      = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        len_q.delete();
        in_block    = 1'b0;
        expect_done = 1'b0;
        vcount      = 0;
      end else begin
        if (expect_done) begin
          chk("done_after_last", {29'd0, done, out_valid, busy}, 32'h4);
          len = (len_q.size() > 0) ? len_q.pop_front() : -1;
          chk("valid_cycle_count", vcount, len);
          expect_done = 1'b0;
          vcount      = 0;
        end else if (done) begin
          chk("unexpected_done", {31'd0, done}, 32'd0);
        end
        if (out_valid) begin
          vcount++;
          if (exp_q.size() == 0) begin
            chk("unexpected_valid", {31'd0, out_valid}, 32'd0);
          end else begin
            it = exp_q.pop_front();
            chk("out_TE_data", {31'd0, out_TE_data}, {31'd0, it.data});
            if (it.chk_par) chk("out_TE_par", {29'd0, out_TE_par}, {29'd0, it.par});
            expect_done = it.last;
            in_block    = ~it.last;
          end
        end else if (in_block) begin
          chk("valid_gap", {31'd0, out_valid}, 32'd1);
          in_block = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [K-1:0] blk;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_TE_data", {31'd0, out_TE_data}, 32'd0);
    chk("rst_out_TE_par", {29'd0, out_TE_par}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // All-zero block, parallel: every output 0
    blk = '0;
    send_block(blk, 1'b1, 1'b0);
    wait_done();

    // Only bit 0 set, parallel: first triplet 3'b111
    blk = '0; blk[0] = 1'b1;
    send_block(blk, 1'b1, 1'b0);
    wait_done();

    // Only bit 13 set, parallel: z' driven at i=1 (pi(1)=13), x at i=13
    blk = '0; blk[13] = 1'b1;
    send_block(blk, 1'b1, 1'b0);
    wait_done();

    // Random block, serial
    for (int i = 0; i < K; i++) blk[i] = 1'($urandom_range(0, 1));
    send_block(blk, 1'b0, 1'b0);
    wait_done();

    // ack pulsed during ENC must be ignored
    for (int i = 0; i < K; i++) blk[i] = 1'($urandom_range(0, 1));
    send_block(blk, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    ack = 1'b1; in_bit = 1'b1; mode = 1'b0;
    chk("busy_during_enc", {31'd0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    ack = 1'b0; in_bit = 1'b0;
    wait_done();

    // Reset mid-ENC aborts the block; the next one still encodes correctly
    for (int i = 0; i < K; i++) blk[i] = 1'($urandom_range(0, 1));
    send_block(blk, 1'b1, 1'b0);
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_TE_data", {31'd0, out_TE_data}, 32'd0);
    chk("midrst_out_TE_par", {29'd0, out_TE_par}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_valid_after_abort", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < K; i++) blk[i] = 1'($urandom_range(0, 1));
    send_block(blk, 1'b0, 1'b0);
    wait_done();

    // Back-to-back blocks, ack on the done cycle, alternating mode
    for (int i = 0; i < K; i++) blk[i] = 1'($urandom_range(0, 1));
    send_block(blk, 1'b1, 1'b1);
    wait_done();
    for (int i = 0; i < K; i++) blk[i] = 1'($urandom_range(0, 1));
    send_block(blk, 1'b0, 1'b1);
    wait_done();
    for (int i = 0; i < K; i++) blk[i] = 1'($urandom_range(0, 1));
    send_block(blk, 1'b1, 1'b1);
    wait_done();

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
